// File: rtl/twiddle_seq_par.sv
// Twiddle-coefficient sequencer: walks a packed complex table with a programmable
// stride and emits LANES coefficients per enabled step, framed by start/last/repeat.
module twiddle_seq_par #(
    parameter int unsigned NBITS = 11,
    parameter int unsigned N     = 32,
    parameter int unsigned LANES = 1,
    parameter int unsigned IW    = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*NBITS*N-1:0]         coeff_tbl,
    input  logic                         start,
    input  logic                         en,
    input  logic [IW-1:0]                stride,
    input  logic                         repeat_mode,
    output logic [2*NBITS*LANES-1:0]     coeff_out,
    output logic                         coeff_valid,
    output logic                         coeff_last,
    output logic                         busy
);

    localparam int unsigned EW    = 2 * NBITS;
    localparam int unsigned FRAME = N / LANES;
    localparam int unsigned CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          base_q, base_d;
    logic [IW-1:0]          stride_q, stride_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [EW*LANES-1:0]    coeff_d;
    logic                   valid_d, last_d;
    logic                   frame_end;

    logic [EW-1:0]          tbl [N];
    logic [IW-1:0]          lane_idx [LANES];
    logic [EW*LANES-1:0]    step_word;

    // Unpack the table so entry 0 (held in the MSBs) becomes tbl[0].
    for (genvar i = 0; i < N; i++) begin : g_tbl
        assign tbl[i] = coeff_tbl[(N-i)*EW-1 -: EW];
    end

    // Lane k reads entry (base + k*stride) mod N; IW-bit wrap gives the modulo.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_idx[k] = base_q + IW'(k) * stride_q;
        assign step_word[(LANES-k)*EW-1 -: EW] = tbl[lane_idx[k]];
    end

    assign frame_end = (cnt_q == CW'(FRAME - 1));

    // Next-state: start (re)launches a frame and takes priority over a step.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;
        coeff_d  = coeff_out;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    stride_d = stride;
                    base_d   = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (start) begin
                    stride_d = stride;
                    base_d   = '0;
                    cnt_d    = '0;
                end else if (en) begin
                    coeff_d = step_word;
                    valid_d = 1'b1;
                    last_d  = frame_end;
                    if (frame_end) begin
                        base_d = '0;
                        cnt_d  = '0;
                        if (!repeat_mode) begin
                            state_d = IDLE;
                        end
                    end else begin
                        base_d = base_q + IW'(LANES) * stride_q;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            stride_q    <= '0;
            cnt_q       <= '0;
            coeff_out   <= '0;
            coeff_valid <= 1'b0;
            coeff_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            cnt_q       <= cnt_d;
            coeff_out   <= coeff_d;
            coeff_valid <= valid_d;
            coeff_last  <= last_d;
            busy        <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_twiddle_seq_par.sv
// Scoreboard bench for twiddle_seq_par (NBITS=11, N=32, LANES=2) against a closed-form frame model.
module tb_twiddle_seq_par;

    localparam int NB = 11;
    localparam int NN = 32;
    localparam int LN = 2;
    localparam int IW = 5;
    localparam int EW = 2 * NB;
    localparam int FR = NN / LN;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [EW*NN-1:0]     coeff_tbl;
    logic                 start = 1'b0;
    logic                 en = 1'b0;
    logic [IW-1:0]        stride = '0;
    logic                 repeat_mode = 1'b0;
    logic [EW*LN-1:0]     coeff_out;
    logic                 coeff_valid;
    logic                 coeff_last;
    logic                 busy;

    twiddle_seq_par #(.NBITS(NB), .N(NN), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .coeff_tbl(coeff_tbl), .start(start), .en(en),
        .stride(stride), .repeat_mode(repeat_mode), .coeff_out(coeff_out),
        .coeff_valid(coeff_valid), .coeff_last(coeff_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [EW*LN-1:0] data;
        logic             last;
    } exp_t;

    exp_t             sb[$];
    int               vectors = 0;
    int               miscompares = 0;
    logic             m_run = 1'b0;
    int               m_stride = 0;
    int               m_step = 0;
    logic [EW*LN-1:0] m_hold = '0;

    function automatic logic [EW-1:0] entry(input int i);
        logic [NB-1:0] re;
        logic [NB-1:0] im;
        re = NB'(i);
        im = NB'(-i);
        return {re, im};
    endfunction

    // Step s of a frame with stride st: lane k reads entry (s*LANES*st + k*st) mod N.
    function automatic logic [EW*LN-1:0] expected_step(input int st, input int s);
        int i0;
        int i1;
        i0 = (s * LN * st) % NN;
        i1 = (s * LN * st + st) % NN;
        return {entry(i0), entry(i1)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check flags afterwards.
    task automatic cycle(input logic s, input logic e, input int st, input logic r);
        logic exp_valid;
        exp_valid   = 1'b0;
        start       = s;
        en          = e;
        stride      = IW'(st);
        repeat_mode = r;
        if (s) begin
            m_run    = 1'b1;
            m_stride = st;
            m_step   = 0;
        end else if (m_run && e) begin
            m_hold = expected_step(m_stride, m_step);
            sb.push_back('{m_hold, (m_step == FR - 1)});
            exp_valid = 1'b1;
            m_step++;
            if (m_step == FR) begin
                m_step = 0;
                if (!r) m_run = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("busy", 64'(busy), 64'(m_run));
        chk("valid", 64'(coeff_valid), 64'(exp_valid));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_coeff"}, 64'(coeff_out), 64'd0);
        chk({name, "_valid"}, 64'(coeff_valid), 64'd0);
        chk({name, "_last"}, 64'(coeff_last), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Asynchronous reset with random inputs; outputs must clear immediately.
    task automatic do_reset(input int n);
        rst    = 1'b0;
        m_run  = 1'b0;
        m_step = 0;
        m_hold = '0;
        #1;
        check_zero("rst_now");
        for (int i = 0; i < n; i++) begin
            start       = 1'($urandom);
            en          = 1'($urandom);
            stride      = IW'($urandom);
            repeat_mode = 1'($urandom);
            @(negedge clk);
            check_zero("rst_hold");
        end
        start = 1'b0;
        rst   = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a coefficient.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (coeff_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(coeff_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("coeff", 64'(coeff_out), 64'(e.data));
                    chk("last", 64'(coeff_last), 64'(e.last));
                end
            end else begin
                chk("hold", 64'(coeff_out), 64'(m_hold));
                chk("last_idle", 64'(coeff_last), 64'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < NN; i++) begin
            coeff_tbl[(NN-i)*EW-1 -: EW] = entry(i);
        end
        #2;
        do_reset(4);
        repeat (3) cycle(1'b0, 1'b1, 0, 1'b0);

        // Stride 1 one-shot frame
        cycle(1'b1, 1'b1, 1, 1'b0);
        repeat (FR) cycle(1'b0, 1'b1, 1, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 0, 1'b0);

        // Stride 5 wraps around the table
        cycle(1'b1, 1'b0, 5, 1'b0);
        repeat (FR) cycle(1'b0, 1'b1, 5, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);

        // Stall pattern 1,0,0,1
        cycle(1'b1, 1'b0, 1, 1'b0);
        cycle(1'b0, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b0, 1, 1'b0);
        cycle(1'b0, 1'b0, 1, 1'b0);
        cycle(1'b0, 1'b1, 1, 1'b0);
        repeat (FR - 2) cycle(1'b0, 1'b1, 1, 1'b0);

        // Repeat mode, stride 2, then drop repeat to end on a frame boundary
        cycle(1'b1, 1'b1, 2, 1'b1);
        repeat (40) cycle(1'b0, 1'b1, 2, 1'b1);
        repeat (8) cycle(1'b0, 1'b1, 2, 1'b0);
        cycle(1'b0, 1'b1, 2, 1'b0);

        // Abort at step 7 with stride 3, then mid-frame reset
        cycle(1'b1, 1'b1, 1, 1'b0);
        repeat (7) cycle(1'b0, 1'b1, 1, 1'b0);
        cycle(1'b1, 1'b1, 3, 1'b0);
        repeat (5) cycle(1'b0, 1'b1, 3, 1'b0);
        do_reset(2);
        repeat (3) cycle(1'b0, 1'b1, 0, 1'b0);

        // Randomized traffic
        repeat (400) begin
            cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, NN - 1)), 1'($urandom));
        end
        cycle(1'b0, 1'b0, 0, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/twiddle_seq_par.md
Name: twiddle_seq_par

Overview:
- Parametrised twiddle-coefficient sequencer for the streaming FFT datapath. Successor to the single-lane, free-running coefficient generators.
- Reads a packed N-entry complex table and emits LANES coefficients per enabled cycle, with programmable stride so one block can serve every butterfly stage.
- Adds start/enable control, one-shot or repeat mode, and valid/last/busy flags so the butterfly pipeline can stall and align to frame boundaries.

Parameters:
- NBITS, 11, width of each real/imag component (two's complement).
- N, 32, table depth; power of 2, N >= 2.
- LANES, 1, coefficients emitted per step; power of 2, LANES <= N.
- IW, $clog2(N), index/stride width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- coeff_tbl  in  2*NBITS*N  packed table. Entry i = coeff_tbl[(N-i)*2*NBITS-1 -: 2*NBITS], so entry 0 is in the MSBs. Each entry is {re[NBITS-1:0], im[NBITS-1:0]}. Static during operation.
- start  in  1  single-cycle request to begin a frame; latches stride.
- en  in  1  advance enable; a step is taken only on cycles with en=1 in RUN.
- stride  in  IW  twiddle exponent step for this stage; sampled only when start is accepted.
- repeat_mode  in  1  1 = restart automatically after the last step; 0 = return to IDLE. Sampled on the last step.
- coeff_out  out  2*NBITS*LANES  lane k is at [(LANES-k)*2*NBITS-1 -: 2*NBITS], lane 0 in the MSBs.
- coeff_valid  out  1  coeff_out was updated on this edge.
- coeff_last  out  1  qualifies the final step of a frame.
- busy  out  1  1 while in RUN.

Behaviour:
- FRAME = N/LANES steps per frame. Internal registers: state {IDLE, RUN}, base[IW-1:0], cnt (0..FRAME-1), stride_q[IW-1:0].
- Reset (rst=0, asynchronous): state=IDLE, base=0, cnt=0, stride_q=0, coeff_out=0, coeff_valid=0, coeff_last=0, busy=0.
- IDLE:
  - start=1 at an edge: stride_q<=stride, base<=0, cnt<=0, state<=RUN.
  - en is ignored in IDLE. No output is produced on the start edge.
- RUN, en=1 at an edge (one step):
  - Lane k: coeff_out lane k <= entry[(base + k*stride_q) mod N]. Arithmetic is IW bits, wrapping.
  - coeff_valid<=1; coeff_last<=(cnt==FRAME-1).
  - base <= (base + LANES*stride_q) mod N; cnt<=cnt+1.
- Frame end (step taken with cnt==FRAME-1):
  - repeat_mode=1: base<=0, cnt<=0, stay in RUN. Back-to-back frames have no bubble.
  - repeat_mode=0: state<=IDLE, busy<=0 on the same edge.
- RUN, en=0: coeff_out holds its value; coeff_valid<=0, coeff_last<=0; base/cnt unchanged (stall).
- IDLE outputs: coeff_out holds its last value; coeff_valid=0, coeff_last=0.
- start=1 while in RUN: abort and restart. Re-latch stride, base<=0, cnt<=0, stay in RUN. No step is taken on that edge, even if en=1; coeff_valid<=0 on that edge.
- Latency: start accepted at edge t. The first coefficient appears at the first edge t'>t with en=1. Minimum 1 cycle after start.
- stride_q=0: every lane and step returns entry 0. stride_q values >= N cannot occur (IW bits).
- busy is registered and equals (state==RUN).
- Reset asserted mid-frame: immediate return to reset values. After release, the block stays in IDLE until start.

Test Plan:
- Test configuration: NBITS=11, N=32, LANES=2; table entry i = {re=i, im=(-i) mod 2^11}.
- Reset: hold rst=0 with random inputs -> all outputs 0, busy=0. Release with start=0 -> outputs remain 0.
- Stride 1, en held high, repeat_mode=0: start pulse -> 16 valid steps on consecutive cycles.
  - Lanes (re) are (0,1), (2,3) … (30,31).
  - coeff_last only on step 16; busy drops on that same edge.
- Stride 5: lanes follow ((10s) mod 32, (10s+5) mod 32) for step s. Step 3 -> (30,3); step 4 -> (8,13). Confirms wrap-around.
- Stall: stride 1 with en toggled 1,0,0,1 -> coeff_valid follows the toggle pattern. coeff_out holds (0,1) through both stall cycles, then becomes (2,3).
- repeat_mode=1, stride 2: after step 16 (lanes (28,30)), the next cycle outputs (0,2) with valid=1 and no gap. coeff_last pulses once every 16 steps.
- Abort: start asserted at step 7 with stride=3 -> valid=0 on that edge. The next en step outputs (0,3). Reset asserted mid-frame -> immediate zeros and IDLE.
